// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU arbiter slice: ALU select
//                codes, flag bit positions and arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU select codes (4-bit)
    localparam logic [3:0] ALU_ADD   = 4'b0000;  // A + B, C = carry out
    localparam logic [3:0] ALU_SUB   = 4'b0001;  // A - B, C = borrow
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOTA  = 4'b0101;
    localparam logic [3:0] ALU_SHL   = 4'b0110;  // C = bit shifted out of A[7]
    localparam logic [3:0] ALU_SHR   = 4'b0111;  // C = bit shifted out of A[0]
    localparam logic [3:0] ALU_INC   = 4'b1000;  // A + 1, C = carry out
    localparam logic [3:0] ALU_DEC   = 4'b1001;  // A - 1, C = borrow
    localparam logic [3:0] ALU_PASSB = 4'b1010;  // all other codes pass A

    // Bit positions inside the {Z,C,S,P} flag nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_P = 0;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu8bit.sv
`default_nettype none
// ============================================================================
//  Module      : ALU8bit
//  Description : Combinational 8-bit ALU producing result Su and the
//                Z (zero), C (carry/borrow), S (sign), P (even parity) flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ALU8bit
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] su,
    output logic       z,
    output logic       c,
    output logic       s,
    output logic       p
);

    // 9-bit working result: bit 8 carries the carry/borrow/shifted-out bit
    logic [8:0] w_res;

    // Operation decode
    always_comb begin
        w_res = 9'd0;
        case (sel)
            ALU_ADD:   w_res = {1'b0, a} + {1'b0, b};
            ALU_SUB:   w_res = {1'b0, a} - {1'b0, b};
            ALU_AND:   w_res = {1'b0, a & b};
            ALU_OR:    w_res = {1'b0, a | b};
            ALU_XOR:   w_res = {1'b0, a ^ b};
            ALU_NOTA:  w_res = {1'b0, ~a};
            ALU_SHL:   w_res = {a, 1'b0};
            ALU_SHR:   w_res = {a[0], 1'b0, a[7:1]};
            ALU_INC:   w_res = {1'b0, a} + 9'd1;
            ALU_DEC:   w_res = {1'b0, a} - 9'd1;
            ALU_PASSB: w_res = {1'b0, b};
            default:   w_res = {1'b0, a};
        endcase
    end

    assign su = w_res[7:0];
    assign c  = w_res[8];
    assign z  = (w_res[7:0] == 8'd0);
    assign s  = w_res[7];
    assign p  = ~^w_res[7:0];

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way combinational arbiter. A lone requester always wins;
//                on a tie the pointer picks the winner when fair, otherwise
//                requester 0 wins. Grant is one-hot or zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    input  logic       fair,
    output logic [1:0] grant
);

    // Tie-break by pointer (fair) or fixed priority to requester 0
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = (fair && rr_ptr) ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one ALU8bit between two requesters. Accepts one
//                request at a time, holds its operands on the ALU for
//                EXEC_CYCLES cycles, captures result and flags, and returns
//                them on a single response channel tagged with the ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter bit FAIR        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       busy
);

    if ((EXEC_CYCLES < 1) || (EXEC_CYCLES > 15)) begin : g_exec_cycles_range
        $error("alu_arbiter: EXEC_CYCLES must lie in 1..15");
    end

    localparam logic [3:0] c_cnt_load = 4'(EXEC_CYCLES - 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic       r_rr_ptr;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_sel;
    logic       r_id;
    logic [3:0] r_cnt;

    logic [1:0] w_grant;
    logic       w_idle;
    logic       w_accept;
    logic [7:0] w_su;
    logic       w_z;
    logic       w_c;
    logic       w_s;
    logic       w_p;
    logic [3:0] w_flags;

    rr_arb2 u_rr_arb2 (
        .valid  ({req1_valid, req0_valid}),
        .rr_ptr (r_rr_ptr),
        .fair   (FAIR),
        .grant  (w_grant)
    );

    // ALU sees only the latched operands, so it is stable throughout EXEC
    ALU8bit u_alu (
        .a   (r_a),
        .b   (r_b),
        .sel (r_sel),
        .su  (w_su),
        .z   (w_z),
        .c   (w_c),
        .s   (w_s),
        .p   (w_p)
    );

    // Pack ALU flags into the {Z,C,S,P} response nibble
    always_comb begin
        w_flags         = 4'b0000;
        w_flags[FLAG_Z] = w_z;
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_S] = w_s;
        w_flags[FLAG_P] = w_p;
    end

    // Grants are offered only in IDLE and never while reset is asserted
    assign w_idle     = (r_state == ST_IDLE);
    assign req0_ready = w_idle & ~rst & w_grant[0];
    assign req1_ready = w_idle & ~rst & w_grant[1];
    assign w_accept   = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = ~w_idle;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)        w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == 4'd0)   w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)       w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, execution counter, result capture and pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= 1'b0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_sel      <= 4'd0;
            r_id       <= 1'b0;
            r_cnt      <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_result <= 8'd0;
            rsp_flags  <= 4'd0;
        end else begin
            if (w_accept) begin
                r_a   <= w_grant[1] ? req1_a   : req0_a;
                r_b   <= w_grant[1] ? req1_b   : req0_b;
                r_sel <= w_grant[1] ? req1_sel : req0_sel;
                r_id  <= w_grant[1];
                r_cnt <= c_cnt_load;
            end
            if (r_state == ST_EXEC) begin
                if (r_cnt == 4'd0) begin
                    rsp_result <= w_su;
                    rsp_flags  <= w_flags;
                    rsp_id     <= r_id;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            // After serving one side, the other side is preferred next
            if ((r_state == ST_RESP) && rsp_ready && FAIR) begin
                r_rr_ptr <= ~r_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. Three instances:
//                0 = EXEC_CYCLES 1 / fair, 1 = EXEC_CYCLES 1 / fixed priority,
//                2 = EXEC_CYCLES 4 / fair. A transaction-level model predicts
//                grants, response timing and golden ALU results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       r0v [3], r0r [3], r1v [3], r1r [3];
    logic       rv  [3], rr  [3], rid [3], bsy [3];
    logic [7:0] a0  [3], b0  [3], a1  [3], b1  [3], res [3];
    logic [3:0] s0  [3], s1  [3], flg [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_arbiter #(
            .EXEC_CYCLES ((g == 2) ? 4 : 1),
            .FAIR        ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0_valid (r0v[g]),
            .req0_ready (r0r[g]),
            .req0_a     (a0[g]),
            .req0_b     (b0[g]),
            .req0_sel   (s0[g]),
            .req1_valid (r1v[g]),
            .req1_ready (r1r[g]),
            .req1_a     (a1[g]),
            .req1_b     (b1[g]),
            .req1_sel   (s1[g]),
            .rsp_valid  (rv[g]),
            .rsp_ready  (rr[g]),
            .rsp_id     (rid[g]),
            .rsp_result (res[g]),
            .rsp_flags  (flg[g]),
            .busy       (bsy[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model state
    bit          m_busy [3];
    int          m_due  [3];
    bit          m_ptr  [3];
    bit          m_id   [3];
    logic [11:0] m_exp  [3];
    int          n_acc [3], n_rsp [3], acc_cyc [3], rsp_first [3], lat_last [3];
    int          glog [3][64];
    int          gcnt [3], acc_limit [3];
    bit          took [3][2], autom [3][2];
    bit          rndmode [3], rndops [3];

    function automatic int ec_of(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic bit fair_of(input int d);
        return (d != 1);
    endfunction

    // Golden ALU, {Z,C,S,P,result}
    function automatic logic [11:0] golden(input int a, input int b, input int sel);
        int t, r, c, ones;
        logic [7:0] r8;
        c = 0; r = 0;
        case (sel)
            0:  begin t = a + b; r = t % 256; c = (t > 255); end
            1:  begin t = a - b; c = (t < 0); r = (t + 256) % 256; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  begin t = a * 2; r = t % 256; c = (t > 255); end
            7:  begin r = a / 2; c = a % 2; end
            8:  begin t = a + 1; r = t % 256; c = (t > 255); end
            9:  begin t = a - 1; c = (t < 0); r = (t + 256) % 256; end
            10: r = b;
            default: r = a;
        endcase
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
        r8 = r[7:0];
        return {(r == 0), (c != 0), (r >= 128), (ones % 2 == 0), r8};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input int d, input int k, input logic v,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        if (k == 0) begin r0v[d] = v; a0[d] = a; b0[d] = b; s0[d] = s; end
        else        begin r1v[d] = v; a1[d] = a; b1[d] = b; s1[d] = s; end
    endtask

    task automatic set_valid(input int d, input int k, input logic v);
        if (k == 0) r0v[d] = v; else r1v[d] = v;
    endtask

    task automatic rnd_req(input int d, input int k);
        set_req(d, k, 1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    endtask

    // One clock: check every instance against the model, advance the model,
    // then update requester behaviour for the next cycle.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            bit idle_now, resp_now, e0, e1, g1;
            idle_now = !m_busy[d];
            resp_now = m_busy[d] && (cyc >= m_due[d]);
            e0 = 1'b0; e1 = 1'b0; g1 = 1'b0;
            if (idle_now && !rst[d]) begin
                if (r0v[d] && r1v[d]) g1 = fair_of(d) ? m_ptr[d] : 1'b0;
                else                  g1 = r1v[d];
                e0 = (r0v[d] || r1v[d]) && !g1;
                e1 = (r0v[d] || r1v[d]) &&  g1;
            end
            chk("req0_ready", r0r[d], e0);
            chk("req1_ready", r1r[d], e1);
            chk("rsp_valid",  rv[d],  resp_now);
            chk("busy",       bsy[d], m_busy[d]);
            if (resp_now) begin
                chk("rsp_id",   rid[d], m_id[d]);
                chk("rsp_data", {flg[d], res[d]}, m_exp[d]);
                if (rsp_first[d] < 0) rsp_first[d] = cyc;
            end
            if (rst[d]) begin
                m_busy[d] = 1'b0;
                m_ptr[d]  = 1'b0;
            end else if (e0 || e1) begin
                m_id[d]  = g1;
                m_exp[d] = g1 ? golden(a1[d], b1[d], s1[d]) : golden(a0[d], b0[d], s0[d]);
                m_due[d] = cyc + ec_of(d) + 1;
                m_busy[d] = 1'b1;
                acc_cyc[d] = cyc;
                rsp_first[d] = -1;
                if (gcnt[d] < 64) glog[d][gcnt[d]] = g1;
                gcnt[d]++;
                n_acc[d]++;
                took[d][g1] = 1'b1;
            end else if (resp_now && rr[d]) begin
                m_busy[d] = 1'b0;
                if (fair_of(d)) m_ptr[d] = !m_id[d];
                n_rsp[d]++;
                lat_last[d] = rsp_first[d] - acc_cyc[d];
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (took[d][k]) begin
                    took[d][k] = 1'b0;
                    if (autom[d][k] && gcnt[d] < acc_limit[d]) begin
                        if (rndops[d]) rnd_req(d, k);
                    end else begin
                        set_valid(d, k, 1'b0);
                    end
                end else if (rndmode[d]) begin
                    if ((k == 0 ? r0v[d] : r1v[d]) && $urandom_range(0, 15) == 0)
                        set_valid(d, k, 1'b0);
                    else if (!(k == 0 ? r0v[d] : r1v[d]) && $urandom_range(0, 2) == 0)
                        rnd_req(d, k);
                end
            end
            if (gcnt[d] >= acc_limit[d]) begin
                set_valid(d, 0, 1'b0);
                set_valid(d, 1, 1'b0);
            end
            if (rndmode[d]) rr[d] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 80 && (m_busy[d] || r0v[d] || r1v[d]); i++) tick();
        chk("drain_idle", {29'd0, m_busy[d], r0v[d], r1v[d]}, 32'd0);
    endtask

    initial begin
        int base, rel;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rr[d] = 1'b1;
            set_req(d, 0, 1'b0, 8'd0, 8'd0, 4'd0);
            set_req(d, 1, 1'b0, 8'd0, 8'd0, 4'd0);
            m_busy[d] = 0; m_ptr[d] = 0; m_id[d] = 0; m_due[d] = 0; m_exp[d] = '0;
            n_acc[d] = 0; n_rsp[d] = 0; acc_cyc[d] = 0; rsp_first[d] = -1; lat_last[d] = 0;
            gcnt[d] = 0; acc_limit[d] = 1000; rndmode[d] = 0; rndops[d] = 0;
            for (int k = 0; k < 2; k++) begin took[d][k] = 0; autom[d][k] = 0; end
        end
        @(posedge clk);
        #1;

        // Reset held 3 cycles with both requests pending on instance 0
        set_req(0, 0, 1'b1, 8'd17, 8'd4, 4'd2);
        set_req(0, 1, 1'b1, 8'd200, 8'd100, 4'd0);
        repeat (3) tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        chk("reset_result", {15'd0, rid[0], flg[0], res[0]}, 32'd0);
        drain(0);
        chk("first_grant", glog[0][0], 0);
        chk("second_grant", glog[0][1], 1);

        // Both requesters continuously valid, fair: strict alternation
        gcnt[0] = 0; acc_limit[0] = 8; base = n_rsp[0];
        autom[0][0] = 1; autom[0][1] = 1;
        set_req(0, 0, 1'b1, 8'd3, 8'd2, 4'b0001);
        set_req(0, 1, 1'b1, 8'd0, 8'd0, 4'b0010);
        drain(0);
        for (int i = 0; i < 8; i++) chk($sformatf("alt_grant%0d", i), glog[0][i], i % 2);
        chk("alt_rsp_count", n_rsp[0] - base, 8);
        autom[0][0] = 0; autom[0][1] = 0; acc_limit[0] = 1000;

        // Single request 3+2, EXEC_CYCLES 1
        base = cyc;
        set_req(0, 0, 1'b1, 8'd3, 8'd2, 4'b0000);
        drain(0);
        chk("single_accept_cycle", acc_cyc[0] - base, 0);
        chk("single_latency", lat_last[0], 2);
        chk("single_id", m_id[0], 0);

        // Fixed priority: requester 1 starves
        gcnt[1] = 0; acc_limit[1] = 6;
        autom[1][0] = 1; autom[1][1] = 1; rndops[1] = 1;
        rnd_req(1, 0); rnd_req(1, 1);
        drain(1);
        chk("fp_grant_count", gcnt[1], 6);
        for (int i = 0; i < 6; i++) chk($sformatf("fp_grant%0d", i), glog[1][i], 0);
        autom[1][0] = 0; autom[1][1] = 0; rndops[1] = 0; acc_limit[1] = 1000;

        // Response stall for 10 cycles with a competing request pending
        rr[0] = 1'b0;
        rnd_req(0, 1);
        for (int i = 0; i < 20 && !(m_busy[0] && cyc >= m_due[0]); i++) tick();
        chk("stall_reached_resp", rv[0], 1'b1);
        rnd_req(0, 0);
        repeat (10) tick();
        rr[0] = 1'b1;
        rel = cyc;
        tick();
        tick();
        chk("release_next_accept", acc_cyc[0], rel + 1);
        chk("release_next_id", m_id[0], 0);
        drain(0);

        // EXEC_CYCLES 4: reset in flight clears pointer and drops response
        rnd_req(2, 0);
        drain(2);
        base = n_acc[2];
        rnd_req(2, 0);
        for (int i = 0; i < 10 && n_acc[2] == base; i++) tick();
        tick();
        tick();
        rst[2] = 1'b1;
        base = n_rsp[2];
        tick();
        rst[2] = 1'b0;
        chk("rst_busy", bsy[2], 1'b0);
        chk("rst_rsp_valid", rv[2], 1'b0);
        repeat (6) tick();
        chk("rst_no_response", n_rsp[2] - base, 0);
        gcnt[2] = 0;
        rnd_req(2, 0); rnd_req(2, 1);
        drain(2);
        chk("rst_ptr_grant", glog[2][0], 0);
        rnd_req(2, 1);
        drain(2);
        chk("ec4_latency", lat_last[2], 5);
        chk("ec4_id", m_id[2], 1);

        // Randomised traffic on instances 0 and 1
        for (int d = 0; d < 2; d++) begin rndmode[d] = 1; rndops[d] = 1; end
        repeat (400) tick();
        for (int d = 0; d < 2; d++) begin rndmode[d] = 0; rr[d] = 1'b1; end
        drain(0);
        drain(1);
        chk("rand0_acc_eq_rsp", n_acc[0] - n_rsp[0], 0);
        chk("rand1_acc_eq_rsp", n_acc[1] - n_rsp[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one ALU8bit instance between two requesters.
- Selects one pending request per transaction, round-robin or fixed-priority.
- Registers its operands, drives the ALU for a programmable number of cycles and captures result plus Z/C/S/P flags.
- Returns the result on a single response channel tagged with the requester ID.
- Sits between the two operand-producing front ends and the shared ALU8bit datapath.

Parameters:
EXEC_CYCLES, 1, cycles operands are held on the ALU before capture; legal 1..15.
FAIR, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  8  requester 0 operand A
req0_b  in  8  requester 0 operand B
req0_sel  in  4  requester 0 ALU select code
req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1
rsp_valid  out  1  response holds a valid result
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the result
rsp_result  out  8  ALU result Su
rsp_flags  out  4  {Z,C,S,P} from ALU
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - State IDLE, rr_ptr=0 (requester 0 preferred first).
  - All outputs 0; operand, result and flag registers 0; exec counter 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready = grant_N, combinational from the valid inputs and rr_ptr. At most one ready high per cycle.
  - Handshake completes in the cycle where valid and ready are both high. On that edge, latch a/b/sel and ID, load counter with EXEC_CYCLES-1, go to EXEC.
  - FAIR=1: both valid -> grant requester rr_ptr; one valid -> grant it regardless of rr_ptr.
  - FAIR=0: requester 0 always wins a tie.
- EXEC:
  - ALU inputs driven only from the latched operand registers, so the ALU is stable for EXEC_CYCLES full cycles.
  - Counter decrements each cycle.
  - At counter==0: capture Su into rsp_result and {Z,C,S,P} into rsp_flags, set rsp_id, go to RESP.
- RESP:
  - rsp_valid=1. result/flags/id held stable until the handshake.
  - On rsp_valid && rsp_ready: rsp_valid falls next cycle, return to IDLE.
  - FAIR=1: rr_ptr set to the requester that was not just served.
- Both reqN_ready stay 0 outside IDLE. Requests arriving during EXEC/RESP wait; their valid must stay asserted and their operands stable.
- Latency: request accepted at edge N -> rsp_valid high from edge N+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles with rsp_ready tied high.
- No pipelining: one transaction in flight.
- Boundary behaviour:
  - rsp_ready low indefinitely: stall in RESP, no further accepts.
  - Valid dropped before grant: no accept, no state change.
  - Both valid every cycle under FAIR=1: grants strictly alternate 0,1,0,1.
  - rst asserted in any state: next edge forces IDLE and reset values, and discards the in-flight transaction (no response).
  - EXEC_CYCLES outside 1..15: elaboration-time error.

Decomposition:
- Shared package alu_pkg holds:
  - ALU select-code constants (4-bit);
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_S=1, FLAG_P=0;
  - FSM state encoding for IDLE/EXEC/RESP.
- One natural sub-module: rr_arb2, a 2-way arbiter with inputs valid[1:0], rr_ptr and fair, and output one-hot grant[1:0]. It is purely combinational.
- ALU8bit is instantiated unchanged.
- Register control stays in alu_arbiter.

Test Plan:
- Reset with both valids high and rst=1 for 3 cycles:
  - required: both readys 0, rsp_valid 0, busy 0;
  - after release, the first grant goes to requester 0.
- req0 only, A=3, B=2, sel=0000, rsp_ready=1, EXEC_CYCLES=1:
  - required: req0_ready at cycle 0, rsp_valid at cycle 2, rsp_id=0;
  - result and flags equal a bench-side golden ALU8bit(3,2,0000).
- Both valid continuously, FAIR=1, req0 (3,2,0001), req1 (0,0,0010):
  - required: grant order 0,1,0,1;
  - req1 response Z flag matches the golden model for operands 0,0;
  - no response lost or duplicated over 8 transactions.
- FAIR=0 with both valid continuously:
  - required: every grant goes to requester 0, requester 1 never served.
- rsp_ready held low 10 cycles in RESP:
  - required: rsp_result/flags/id stable, both readys 0;
  - release -> rsp_valid drops the next cycle and the next grant follows.
- EXEC_CYCLES=4, then rst pulsed during EXEC:
  - required: no rsp_valid, state IDLE next cycle, rr_ptr=0;
  - a subsequent req1 transaction completes with 5-cycle latency.
